imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory from a byte stream, the write-side counterpart to the datapath's instruction fetch path. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake, assembles 32-bit words, and issues one write per word at consecutive word addresses. It holds the processor core in reset while loading and releases it on completion.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-address width of the instruction memory; capacity is 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0: byte address of the first word written.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR.
- RxByte  in  8  stream byte.
- RxValid  in  1  RxByte valid.
- RxReady  out  1  loader accepts a byte this cycle.
- MemWrEn  out  1  single-cycle instruction-memory write strobe.
- MemWrAddr  out  32  byte address of write, word aligned.
- MemWrData  out  32  word to write.
- CpuHold  out  1  drives the core's Reset; high while loading.
- Done  out  1  load completed successfully (level).
- Error  out  1  load aborted (level).
- WordCount  out  ADDR_WIDTH+1  words written so far.

## Operation
- A byte transfers on any cycle with RxValid && RxReady; bytes arrive MSB first (byte 0 → [31:24]).
- FSM states:
  - IDLE: outputs quiet. On Start, go to HDR.
  - HDR: receive the 4-byte word count N. If N == 0, go to DONE. If N > 2^ADDR_WIDTH, go to ERR. Otherwise go to LOAD.
  - LOAD: receive N words. Word k writes to BASE_ADDR + 4k. After word N is accepted, go to DONE (or CHK when the checksum is compiled in).
  - DONE / ERR: terminal states. Start re-enters HDR and clears Done, Error and WordCount.
- RxReady is 1 in HDR, LOAD and CHK, and 0 otherwise.
- The byte counter is 2 bits and wraps 3→0 when a word completes.
- The word index saturates at N. No write ever goes past word N−1.
- CpuHold is set on the Start edge and cleared on entry to DONE. It stays 1 in ERR, so a partial image never runs.
- A Start pulse in HDR, LOAD or CHK is ignored.
- Reset in any state returns to IDLE. No write is issued in the reset cycle, and a partial word is discarded.

## Timing
- Reset values: RxReady=0, MemWrEn=0, MemWrAddr=BASE_ADDR, MemWrData=0, CpuHold=0, Done=0, Error=0, WordCount=0.
- Write latency: MemWrEn is asserted in the cycle after the 4th byte of a word is accepted, for exactly 1 cycle. MemWrAddr and MemWrData are registered and stable in that cycle. WordCount increments in the same cycle.
- Full throughput is 1 byte/cycle. RxReady does not drop during the write cycle, so bytes of the next word may be accepted while the previous write is strobed.
- Done and Error rise 1 cycle after the last accepted byte: the last header byte when N == 0, otherwise the last data byte or last checksum byte. For the last data word, MemWrEn and Done are asserted in the same cycle.
- CpuHold falls in the same cycle Done rises.
- The loader is held for 4N+4 byte transfers minimum (plus 4 with checksum).

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After LOAD, state CHK receives one more 4-byte word.
  - If it equals the XOR of all N data words, go to DONE. Otherwise go to ERR with CpuHold=1.
  - The checksum word is never written to memory.
- LOADER_CHECKSUM_EN undefined: the CHK state and the XOR register are absent, and LOAD goes directly to DONE.

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE, HDR, LOAD, CHK, DONE, ERR);
  - the constant WORD_BYTES = 4.
- One sub-module, byte_word_assembler: the shift register plus 2-bit byte counter, with a word_valid pulse output. It is reused for both header and data words.

## Test plan
- N=3, words 0x20080005, 0x21290001, 0x00000000, BASE_ADDR=0, RxValid held 1 → three MemWrEn pulses, at addresses 0, 4, 8, each one cycle after that word's 4th byte. Done=1 and CpuHold=0 one cycle after the last byte. WordCount=3.
- N=0 → no writes; Done=1 one cycle after the 4th header byte.
- ADDR_WIDTH=8, N=257 → Error=1 after the header, no MemWrEn, CpuHold stays 1, RxReady=0.
- RxValid toggling 1/0 every cycle during N=2 → same addresses and data as a full-rate run; each MemWrEn lasts exactly 1 cycle.
- Reset asserted after 2 bytes of word 1 → next cycle all outputs at reset values. A following Start with N=1 writes address 0 with the new data only.
- With LOADER_CHECKSUM_EN, N=2, words 0xAAAA0000 and 0x0000BBBB:
  - checksum 0xAAAABBBB → Done=1;
  - checksum 0xAAAABBBA → Error=1 and CpuHold=1.
  - In both cases exactly 2 writes are issued.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

  // Byte address of word idx in an image based at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_assembler.sv
// Big-endian byte-to-word assembler; word_valid pulses combinationally with the
// 4th accepted byte, and word already includes that byte.
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_CNT_W-1:0] cnt;
  logic [23:0]           shreg;

  assign word       = {shreg, din};
  assign word_valid = en && (cnt == BYTE_CNT_W'(WORD_BYTES - 1));

  // Counter wraps 3->0 on word completion, so no explicit clear is needed there.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (en) begin
      cnt   <= cnt + 1'b1;
      shreg <= {shreg[15:0], din};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the instruction memory; holds the core
// in reset while loading. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [7:0]          RxByte,
  input  logic                RxValid,
  output logic                RxReady,
  output logic                MemWrEn,
  output logic [31:0]         MemWrAddr,
  output logic [31:0]         MemWrData,
  output logic                CpuHold,
  output logic                Done,
  output logic                Error,
  output logic [ADDR_WIDTH:0] WordCount
);

  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

  state_t              state;
  logic [ADDR_WIDTH:0] nwords;
  logic                accept;
  logic                restart;
  logic                word_valid;
  logic [31:0]         word;
  logic                last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]         csum;
`endif

  assign accept    = RxValid && RxReady;
  assign restart   = Start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign last_word = ((WordCount + 1'b1) == nwords);

  byte_word_assembler u_asm (
    .clk        (Clock),
    .rst        (Reset),
    .clr        (restart),
    .en         (accept),
    .din        (RxByte),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      RxReady   <= 1'b0;
      MemWrEn   <= 1'b0;
      MemWrAddr <= BASE_ADDR;
      MemWrData <= '0;
      CpuHold   <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      WordCount <= '0;
      nwords    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      MemWrEn <= 1'b0;
      if (restart) begin
        state     <= S_HDR;
        RxReady   <= 1'b1;
        CpuHold   <= 1'b1;
        Done      <= 1'b0;
        Error     <= 1'b0;
        WordCount <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum      <= '0;
`endif
      end else begin
        case (state)
          S_HDR: if (word_valid) begin
            if (word == 32'h0) begin
              state   <= S_DONE;
              RxReady <= 1'b0;
              CpuHold <= 1'b0;
              Done    <= 1'b1;
            end else if ({1'b0, word} > CAPACITY) begin
              state   <= S_ERR;
              RxReady <= 1'b0;
              Error   <= 1'b1;
            end else begin
              state  <= S_LOAD;
              nwords <= word[ADDR_WIDTH:0];
            end
          end
          S_LOAD: if (word_valid) begin
            MemWrEn   <= 1'b1;
            MemWrAddr <= word_addr(BASE_ADDR, 32'(WordCount));
            MemWrData <= word;
            WordCount <= WordCount + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ word;
            if (last_word) state <= S_CHK;
`else
            if (last_word) begin
              state   <= S_DONE;
              RxReady <= 1'b0;
              CpuHold <= 1'b0;
              Done    <= 1'b1;
            end
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          // Checksum word is compared only, never written; a bad image keeps the core held.
          S_CHK: if (word_valid) begin
            RxReady <= 1'b0;
            if (word == csum) begin
              state   <= S_DONE;
              CpuHold <= 1'b0;
              Done    <= 1'b1;
            end else begin
              state <= S_ERR;
              Error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a queue-based write reference.
module tb_imem_loader;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          CAP  = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset, Start, RxValid;
  logic [7:0]    RxByte;
  logic          RxReady, MemWrEn, CpuHold, Done, Error;
  logic [31:0]   MemWrAddr, MemWrData;
  logic [AW:0]   WordCount;

  int            checks = 0;
  int            failures = 0;
  logic [31:0]   img[$];
  logic [63:0]   wr_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .RxByte    (RxByte),
    .RxValid   (RxValid),
    .RxReady   (RxReady),
    .MemWrEn   (MemWrEn),
    .MemWrAddr (MemWrAddr),
    .MemWrData (MemWrData),
    .CpuHold   (CpuHold),
    .Done      (Done),
    .Error     (Error),
    .WordCount (WordCount)
  );

  always #5 Clock = ~Clock;

  // Every strobed cycle is logged, so a stretched strobe shows up as an extra write.
  always @(negedge Clock) if (MemWrEn === 1'b1) wr_q.push_back({MemWrAddr, MemWrData});

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
    int t;
    repeat ($urandom_range(hi, lo)) begin RxValid = 1'b0; tick(); end
    RxValid = 1'b1; RxByte = b; t = 0;
    while (RxReady !== 1'b1 && t < 20) begin tick(); t++; end
    if (t == 20) chk("rxready_timeout", 64'(RxReady), 64'd1);
    tick();
    RxValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int lo, input int hi);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], lo, hi);
  endtask

  // Full load against the model: word k -> BASE+4k, Done iff image fits (and checksum matches).
  task automatic run_load(input logic [31:0] n, input int lo, input int hi,
                          input bit bad_cs, input bit mid_start, input string tag);
    logic [31:0] cs;
    int          exp_writes;
    bit          ok;
    pulse_start();
    chk({tag, ":hold_start"}, 64'(CpuHold), 64'd1);
    chk({tag, ":rdy_start"}, 64'(RxReady), 64'd1);
    chk({tag, ":done_clr"}, 64'(Done), 64'd0);
    wr_q.delete();
    send_word(n, lo, hi);
    exp_writes = 0;
    ok = 1'b1;
    if (n == 0) begin
      chk({tag, ":wren_n0"}, 64'(MemWrEn), 64'd0);
    end else if (n > CAP) begin
      ok = 1'b0;
      chk({tag, ":wren_ovf"}, 64'(MemWrEn), 64'd0);
    end else begin
      cs = 32'h0;
      for (int k = 0; k < int'(n); k++) begin
        send_word(img[k], lo, hi);
        chk({tag, $sformatf(":wren%0d", k)}, 64'(MemWrEn), 64'd1);
        chk({tag, $sformatf(":addr%0d", k)}, 64'(MemWrAddr), 64'(BASE + 32'(4 * k)));
        chk({tag, $sformatf(":data%0d", k)}, 64'(MemWrData), 64'(img[k]));
        chk({tag, $sformatf(":wc%0d", k)}, 64'(WordCount), 64'(k + 1));
        cs ^= img[k];
        if (mid_start && k == 0) pulse_start();
      end
      exp_writes = int'(n);
`ifdef LOADER_CHECKSUM_EN
      send_word(bad_cs ? (cs ^ 32'h1) : cs, lo, hi);
      chk({tag, ":wren_cs"}, 64'(MemWrEn), 64'd0);
      ok = !bad_cs;
`endif
    end
    chk({tag, ":done"}, 64'(Done), 64'(ok));
    chk({tag, ":error"}, 64'(Error), 64'(!ok));
    chk({tag, ":hold"}, 64'(CpuHold), 64'(!ok));
    chk({tag, ":rdy_end"}, 64'(RxReady), 64'd0);
    repeat (3) tick();
    chk({tag, ":nwrites"}, 64'(wr_q.size()), 64'(exp_writes));
    for (int k = 0; k < exp_writes && k < wr_q.size(); k++)
      chk({tag, $sformatf(":log%0d", k)}, wr_q[k], {BASE + 32'(4 * k), img[k]});
    if (n <= CAP) chk({tag, ":wc_final"}, 64'(WordCount), 64'(n));
    else chk({tag, ":wc_final"}, 64'(WordCount), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":rdy"}, 64'(RxReady), 64'd0);
    chk({tag, ":wren"}, 64'(MemWrEn), 64'd0);
    chk({tag, ":addr"}, 64'(MemWrAddr), 64'(BASE));
    chk({tag, ":data"}, 64'(MemWrData), 64'd0);
    chk({tag, ":hold"}, 64'(CpuHold), 64'd0);
    chk({tag, ":done"}, 64'(Done), 64'd0);
    chk({tag, ":err"}, 64'(Error), 64'd0);
    chk({tag, ":wc"}, 64'(WordCount), 64'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; RxValid = 1'b0; RxByte = 8'h00;
    repeat (2) tick();
    chk_reset_vals("por");
    Reset = 1'b0;
    tick();

    img = '{32'h2008_0005, 32'h2129_0001, 32'h0000_0000};
    run_load(32'd3, 0, 0, 1'b0, 1'b0, "basic");
    run_load(32'd0, 0, 0, 1'b0, 1'b0, "n0");
    run_load(32'(CAP + 1), 0, 0, 1'b0, 1'b0, "ovf");
    chk("ovf:rdy_hold", 64'(RxReady), 64'd0);
    run_load(32'hFFFF_FFFF, 0, 1, 1'b0, 1'b0, "ovf_max");

    img = '{32'hCAFE_F00D, 32'h0BAD_BEEF};
    run_load(32'd2, 1, 1, 1'b0, 1'b0, "toggle");
    run_load(32'd2, 0, 2, 1'b0, 1'b1, "ign_start");

    // Reset mid-word: partial bytes must be dropped.
    img = '{32'hDEAD_BEEF};
    pulse_start();
    wr_q.delete();
    send_word(32'd1, 0, 0);
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk_reset_vals("mid_rst");
    chk("mid_rst:nwrites", 64'(wr_q.size()), 64'd0);
    img = '{32'h1234_5678};
    run_load(32'd1, 0, 0, 1'b0, 1'b0, "after_rst");

`ifdef LOADER_CHECKSUM_EN
    img = '{32'hAAAA_0000, 32'h0000_BBBB};
    run_load(32'd2, 0, 0, 1'b0, 1'b0, "cs_good");
    run_load(32'd2, 0, 0, 1'b1, 1'b0, "cs_bad");
`endif

    img.delete();
    for (int k = 0; k < CAP; k++) img.push_back($urandom);
    run_load(32'(CAP), 0, 0, 1'b0, 1'b0, "full_cap");

    for (int it = 0; it < 12; it++) begin
      int unsigned n;
      n = $urandom_range(6, 1);
      img.delete();
      for (int k = 0; k < int'(n); k++) img.push_back($urandom);
      run_load(32'(n), 0, 2, 1'($urandom_range(1, 0)), 1'b0, $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
